// File: rtl/cw_capture_buf.sv
// Capture buffer behind the ChipWatcher: stores strobed samples in a circular RAM
// and replays them oldest-first over a valid/ready stream once the session ends.
module cw_capture_buf #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              trig_clk,
   input  logic              trig_rstn,
   input  logic              wt_ce,
   input  logic              wt_en,
   input  logic [15:0]       wt_addr,
   input  logic [DATA_W-1:0] bus_din,
   input  logic              rd_req,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              cap_done,
   output logic              wrapped,
   output logic [ADDR_W:0]   sample_cnt,
   output logic              busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2,
      ST_READ    = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [ADDR_W-1:0]   r_last_addr;
   logic [CNT_W-1:0]    r_sample_cnt;
   logic                r_wrapped;
   logic                r_cap_done;
   logic                r_busy;

   logic [ADDR_W-1:0]   r_rd_addr;
   logic [CNT_W-1:0]    r_rd_remain;
   logic [DATA_W-1:0]   r_ram_q;
   logic                r_ram_v;
   logic                r_ram_last;

   logic [DATA_W-1:0]   r_q0_data, r_q1_data;
   logic                r_q0_last, r_q1_last;
   logic                r_q0_v,    r_q1_v;
   logic [DATA_W-1:0]   w_q0_data, w_q1_data;
   logic                w_q0_last, w_q1_last;
   logic                w_q0_v,    w_q1_v;

   logic                w_wr;
   logic [ADDR_W-1:0]   w_waddr;
   logic                w_new_session;
   logic                w_abort;
   logic                w_start;
   logic                w_pop;
   logic                w_issue;
   logic [1:0]          w_hold;

   assign w_waddr       = wt_addr[ADDR_W-1:0];
   assign w_wr          = wt_ce & wt_en & (r_state != ST_IDLE);
   assign w_abort       = wt_ce & ((r_state == ST_DONE) | (r_state == ST_READ));
   assign w_new_session = ((r_state == ST_IDLE) & wt_ce) | w_abort;
   assign w_start       = (r_state == ST_DONE) & rd_req & ~wt_ce;
   assign w_pop         = r_q0_v & rd_ready;

   // Items held after this edge (skid entries + RAM stage) must stay within two.
   assign w_hold  = 2'(r_q0_v) + 2'(r_q1_v) + 2'(r_ram_v) - 2'(w_pop);
   assign w_issue = (r_state == ST_READ) & ~wt_ce & (r_rd_remain != '0) & (w_hold < 2'd2);

   generate
      if (ADDR_W < 16) begin : g_addr_unused
         logic w_unused_addr;
         assign w_unused_addr = &{1'b0, wt_addr[15:ADDR_W]};
      end
   endgenerate

   // State register
   always_ff @(posedge trig_clk) begin
      if (!trig_rstn) r_state <= ST_IDLE;
      else            r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (wt_ce) w_state_nxt = ST_CAPTURE;
         ST_CAPTURE: if (!wt_ce) w_state_nxt = (r_sample_cnt != '0) ? ST_DONE : ST_IDLE;
         ST_DONE:    if (wt_ce) w_state_nxt = ST_CAPTURE;
                     else if (rd_req) w_state_nxt = ST_READ;
         ST_READ:    if (wt_ce) w_state_nxt = ST_CAPTURE;
                     else if (w_pop && r_q0_last) w_state_nxt = ST_DONE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Sample RAM: one write port, one registered read port
   always_ff @(posedge trig_clk) begin
      if (w_wr) r_mem[w_waddr] <= bus_din;
      if (w_issue) r_ram_q <= r_mem[r_rd_addr];
   end

   // Capture bookkeeping
   always_ff @(posedge trig_clk) begin
      if (!trig_rstn) begin
         r_sample_cnt <= '0;
         r_wrapped    <= 1'b0;
         r_cap_done   <= 1'b0;
         r_last_addr  <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == ST_CAPTURE) || (w_state_nxt == ST_READ);
         if (w_new_session) begin
            r_cap_done   <= 1'b0;
            r_wrapped    <= 1'b0;
            r_sample_cnt <= w_wr ? CNT_W'(1) : '0;
         end else if (w_wr) begin
            if (r_sample_cnt != CNT_W'(DEPTH)) r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            if (r_sample_cnt == CNT_W'(DEPTH - 1)) r_wrapped <= 1'b1;
         end
         if (w_wr) r_last_addr <= w_waddr;
         if ((r_state == ST_CAPTURE) && !wt_ce && (r_sample_cnt != '0)) r_cap_done <= 1'b1;
      end
   end

   // Read address generator; sample_cnt already saturates at DEPTH when wrapped
   always_ff @(posedge trig_clk) begin
      if (!trig_rstn) begin
         r_rd_addr   <= '0;
         r_rd_remain <= '0;
         r_ram_v     <= 1'b0;
         r_ram_last  <= 1'b0;
      end else begin
         if (w_start) begin
            r_rd_addr   <= r_wrapped ? r_last_addr + ADDR_W'(1) : '0;
            r_rd_remain <= r_sample_cnt;
         end else if (w_issue) begin
            r_rd_addr   <= r_rd_addr + ADDR_W'(1);
            r_rd_remain <= r_rd_remain - CNT_W'(1);
         end else if (w_abort) begin
            r_rd_remain <= '0;
         end
         r_ram_v    <= w_issue;
         r_ram_last <= w_issue && (r_rd_remain == CNT_W'(1));
      end
   end

   // Two-entry skid buffer; entry 0 drives the output port
   always_comb begin
      w_q0_data = r_q0_data;
      w_q0_last = r_q0_last;
      w_q0_v    = r_q0_v;
      w_q1_data = r_q1_data;
      w_q1_last = r_q1_last;
      w_q1_v    = r_q1_v;
      if (w_pop) begin
         w_q0_data = r_q1_data;
         w_q0_last = r_q1_last;
         w_q0_v    = r_q1_v;
         w_q1_v    = 1'b0;
      end
      if (r_ram_v) begin
         if (!w_q0_v) begin
            w_q0_data = r_ram_q;
            w_q0_last = r_ram_last;
            w_q0_v    = 1'b1;
         end else begin
            w_q1_data = r_ram_q;
            w_q1_last = r_ram_last;
            w_q1_v    = 1'b1;
         end
      end
   end

   always_ff @(posedge trig_clk) begin
      if (!trig_rstn) begin
         r_q0_data <= '0;
         r_q0_last <= 1'b0;
         r_q0_v    <= 1'b0;
         r_q1_data <= '0;
         r_q1_last <= 1'b0;
         r_q1_v    <= 1'b0;
      end else if (w_abort) begin
         r_q0_v    <= 1'b0;
         r_q0_last <= 1'b0;
         r_q1_v    <= 1'b0;
      end else begin
         r_q0_data <= w_q0_data;
         r_q0_last <= w_q0_last;
         r_q0_v    <= w_q0_v;
         r_q1_data <= w_q1_data;
         r_q1_last <= w_q1_last;
         r_q1_v    <= w_q1_v;
      end
   end

   assign rd_valid   = r_q0_v;
   assign rd_data    = r_q0_data;
   assign rd_last    = r_q0_last;
   assign cap_done   = r_cap_done;
   assign wrapped    = r_wrapped;
   assign sample_cnt = r_sample_cnt;
   assign busy       = r_busy;

endmodule

// File: tb/tb_cw_capture_buf.sv
// Self-checking bench for cw_capture_buf: session-level reference model with a
// per-cycle compare process, plus directed scenarios with literal expectations.
module tb_cw_capture_buf;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DEPTH  = 16;

   logic              trig_clk;
   logic              trig_rstn;
   logic              wt_ce;
   logic              wt_en;
   logic [15:0]       wt_addr;
   logic [DATA_W-1:0] bus_din;
   logic              rd_req;
   logic              rd_ready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;
   logic              cap_done;
   logic              wrapped;
   logic [ADDR_W:0]   sample_cnt;
   logic              busy;

   cw_capture_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .trig_clk   (trig_clk),
      .trig_rstn  (trig_rstn),
      .wt_ce      (wt_ce),
      .wt_en      (wt_en),
      .wt_addr    (wt_addr),
      .bus_din    (bus_din),
      .rd_req     (rd_req),
      .rd_ready   (rd_ready),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_last    (rd_last),
      .cap_done   (cap_done),
      .wrapped    (wrapped),
      .sample_cnt (sample_cnt),
      .busy       (busy)
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 0;

   // Reference model: session flags, sample memory and the expected dump order
   bit              m_cap_active = 0;
   bit              m_have_cap   = 0;
   bit              m_dumping    = 0;
   bit              m_wrapped    = 0;
   bit              m_acc        = 0;
   int              m_cnt        = 0;
   int              m_last       = 0;
   int              m_start      = 0;
   logic [15:0]     m_mem [DEPTH];
   logic [15:0]     m_expq [$];

   bit              mon_hs = 0;
   logic            pv = 0, pr = 0, pl = 0;
   logic [15:0]     pd = '0;
   logic [16:0]     got_q [$];
   logic [31:0]     exp_q [$];

   initial begin
      trig_clk = 1'b0;
      forever #5 trig_clk = ~trig_clk;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge trig_clk);
      #1;
   endtask

   // Model update at each active edge from the inputs the DUT sees
   initial forever begin
      @(posedge trig_clk);
      if (!trig_rstn) begin
         m_cap_active = 0; m_have_cap = 0; m_dumping = 0;
         m_cnt = 0; m_wrapped = 0; m_expq.delete();
      end else if (wt_ce) begin
         if (!m_cap_active) begin
            m_acc = m_have_cap;
            m_cap_active = 1; m_have_cap = 0; m_dumping = 0;
            m_cnt = 0; m_wrapped = 0; m_expq.delete();
         end else begin
            m_acc = 1;
         end
         if (m_acc && wt_en) begin
            m_last = int'(wt_addr) % DEPTH;
            m_mem[m_last] = bus_din;
            if (m_cnt < DEPTH) m_cnt++;
            if (m_cnt == DEPTH) m_wrapped = 1;
         end
      end else if (m_cap_active) begin
         m_cap_active = 0;
         m_have_cap = (m_cnt > 0);
      end else if (m_dumping) begin
         if (mon_hs) void'(m_expq.pop_front());
         if (m_expq.size() == 0) m_dumping = 0;
      end else if (m_have_cap && rd_req) begin
         m_start = m_wrapped ? (m_last + 1) % DEPTH : 0;
         for (int i = 0; i < m_cnt; i++) m_expq.push_back(m_mem[(m_start + i) % DEPTH]);
         m_dumping = 1;
      end
   end

   // Per-cycle compare against the model, sampled mid-cycle
   initial forever begin
      @(negedge trig_clk);
      if (chk_en) begin
         check("cap_done", 32'(cap_done), 32'(m_have_cap));
         check("wrapped", 32'(wrapped), 32'(m_wrapped));
         check("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
         check("busy", 32'(busy), 32'(m_cap_active || m_dumping));
         if (!m_dumping || m_expq.size() == 0) begin
            check("rd_valid_idle", 32'(rd_valid), 32'd0);
         end else if (rd_valid) begin
            check("rd_data_model", 32'(rd_data), 32'(m_expq[0]));
            check("rd_last_model", 32'(rd_last), 32'(m_expq.size() == 1));
         end
         if (pv && !pr && m_dumping) begin
            check("stall_valid", 32'(rd_valid), 32'd1);
            check("stall_data", 32'(rd_data), 32'(pd));
            check("stall_last", 32'(rd_last), 32'(pl));
         end
         mon_hs = rd_valid && rd_ready;
         if (mon_hs) got_q.push_back({rd_last, rd_data});
         pv = rd_valid; pr = rd_ready; pd = rd_data; pl = rd_last;
      end else begin
         mon_hs = 0;
      end
   end

   task automatic start_dump();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   // Wait (bounded) for n handshakes, optionally toggling rd_ready
   task automatic collect(input int n, input bit rnd);
      for (int c = 0; c < 400 && got_q.size() < n; c++) begin
         if (rnd) rd_ready = 1'($urandom_range(0, 1));
         tick();
      end
      rd_ready = 1'b1;
      tick();
   endtask

   task automatic expect_seq(input string nm);
      check({nm, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         check({nm, "_data"}, 32'(got_q[i][15:0]), exp_q[i]);
         check({nm, "_last"}, 32'(got_q[i][16]), 32'(i == exp_q.size() - 1));
      end
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, "_rd_valid"}, 32'(rd_valid), 32'd0);
      check({nm, "_rd_data"}, 32'(rd_data), 32'd0);
      check({nm, "_rd_last"}, 32'(rd_last), 32'd0);
      check({nm, "_cap_done"}, 32'(cap_done), 32'd0);
      check({nm, "_wrapped"}, 32'(wrapped), 32'd0);
      check({nm, "_sample_cnt"}, 32'(sample_cnt), 32'd0);
      check({nm, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      trig_rstn = 1'b0; wt_ce = 1'b0; wt_en = 1'b0; wt_addr = '0;
      bus_din = '0; rd_req = 1'b0; rd_ready = 1'b1;
      tick();
      chk_en = 1;
      tick();
      check_reset_outputs("reset");
      trig_rstn = 1'b1;
      tick();

      // Basic capture: five samples at addresses 0..4
      wt_ce = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         wt_en = 1'b1; wt_addr = 16'(i); bus_din = 16'(32'hA0 + i);
         tick();
      end
      check("cap_busy", 32'(busy), 32'd1);
      check("cap_done_early", 32'(cap_done), 32'd0);
      wt_en = 1'b0; wt_ce = 1'b0;
      tick();
      check("basic_cap_done", 32'(cap_done), 32'd1);
      check("basic_cnt", 32'(sample_cnt), 32'd5);
      check("basic_wrapped", 32'(wrapped), 32'd0);
      check("basic_busy", 32'(busy), 32'd0);

      // Linear dump with rd_ready high; first data two edges after rd_req
      got_q.delete();
      rd_ready = 1'b1;
      start_dump();
      check("lat_e0_valid", 32'(rd_valid), 32'd0);
      check("lat_e0_busy", 32'(busy), 32'd1);
      tick();
      check("lat_e1_valid", 32'(rd_valid), 32'd0);
      tick();
      check("lat_e2_valid", 32'(rd_valid), 32'd1);
      check("lat_e2_data", 32'(rd_data), 32'hA0);
      collect(5, 0);
      exp_q.delete();
      for (int i = 0; i < 5; i++) exp_q.push_back(32'hA0 + 32'(i));
      expect_seq("linear");
      check("linear_busy_end", 32'(busy), 32'd0);
      check("linear_cap_kept", 32'(cap_done), 32'd1);

      // Wrap: 20 writes into a 16-entry RAM
      wt_ce = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) begin
         wt_en = 1'b1; wt_addr = 16'(i % 16); bus_din = 16'(i);
         tick();
      end
      wt_en = 1'b0; wt_ce = 1'b0;
      tick();
      check("wrap_wrapped", 32'(wrapped), 32'd1);
      check("wrap_cnt", 32'(sample_cnt), 32'd16);
      check("wrap_cap_done", 32'(cap_done), 32'd1);
      exp_q.delete();
      for (int i = 4; i < 20; i++) exp_q.push_back(32'(i));
      got_q.delete();
      start_dump();
      collect(16, 0);
      expect_seq("wrap");

      // Backpressure: same capture dumped again with random rd_ready
      got_q.delete();
      start_dump();
      collect(16, 1);
      expect_seq("bp");

      // Abort mid-dump, with a write accepted in the abort cycle
      got_q.delete();
      rd_ready = 1'b0;
      start_dump();
      tick();
      tick();
      check("abort_pre_valid", 32'(rd_valid), 32'd1);
      check("abort_pre_data", 32'(rd_data), 32'd4);
      tick();
      check("abort_stall_data", 32'(rd_data), 32'd4);
      wt_ce = 1'b1; wt_en = 1'b1; wt_addr = 16'd0; bus_din = 16'h0055;
      tick();
      check("abort_valid", 32'(rd_valid), 32'd0);
      check("abort_cap_done", 32'(cap_done), 32'd0);
      check("abort_busy", 32'(busy), 32'd1);
      check("abort_cnt", 32'(sample_cnt), 32'd1);
      check("abort_wrapped", 32'(wrapped), 32'd0);
      wt_addr = 16'd1; bus_din = 16'h0066;
      tick();
      wt_en = 1'b0; wt_ce = 1'b0; rd_ready = 1'b1;
      tick();
      check("abort_new_done", 32'(cap_done), 32'd1);
      check("abort_new_cnt", 32'(sample_cnt), 32'd2);
      exp_q.delete();
      exp_q.push_back(32'h55);
      exp_q.push_back(32'h66);
      got_q.delete();
      start_dump();
      collect(2, 0);
      expect_seq("abort_dump");

      // Synchronous reset in the middle of a capture
      wt_ce = 1'b1;
      tick();
      wt_en = 1'b1; wt_addr = 16'd2; bus_din = 16'h0077;
      tick();
      tick();
      trig_rstn = 1'b0;
      tick();
      check_reset_outputs("midreset");
      trig_rstn = 1'b1; wt_en = 1'b0; wt_ce = 1'b0;
      tick();

      // Empty session returns to idle and ignores rd_req
      wt_ce = 1'b1;
      tick();
      check("empty_busy_cap", 32'(busy), 32'd1);
      wt_ce = 1'b0;
      tick();
      check("empty_busy", 32'(busy), 32'd0);
      check("empty_cap_done", 32'(cap_done), 32'd0);
      start_dump();
      tick();
      tick();
      check("empty_rd_valid", 32'(rd_valid), 32'd0);
      check("empty_busy_rd", 32'(busy), 32'd0);
      tick();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
